// File: rtl/jacobian_to_affine.sv
// Jacobian-to-affine point conversion sequencer.
// Drives an external field-arithmetic engine through five operations
// (inv, squ, mul, mul, mul) to compute x = X/Z^2 and y = Y/Z^3.
// Engine handshake: the block drives a non-zero eng_mode for exactly one cycle
// along with eng_a/eng_b. It then holds eng_mode at 00 with the operands stable.
// eng_res is taken on the first eng_finish=1 seen after the wait-state entry
// cycle, because the engine's finish flag may still be set from the previous operation.
module jacobian_to_affine #(
    parameter int DW = 257
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] X,
    input  logic [DW-1:0] Y,
    input  logic [DW-1:0] Z,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic          inf,
    output logic [1:0]    eng_mode,
    output logic [DW-1:0] eng_a,
    output logic [DW-1:0] eng_b,
    input  logic [DW-1:0] eng_res,
    input  logic          eng_finish,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CHECK = 4'd1,
        ISS1  = 4'd2,
        ISS2  = 4'd3,
        ISS3  = 4'd4,
        ISS4  = 4'd5,
        ISS5  = 4'd6,
        WT1   = 4'd7,
        WT2   = 4'd8,
        WT3   = 4'd9,
        WT4   = 4'd10,
        WT5   = 4'd11,
        FIN   = 4'd12
    } state_t;

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_MUL  = 2'b01;
    localparam logic [1:0] M_SQU  = 2'b10;
    localparam logic [1:0] M_INV  = 2'b11;

    state_t        state;
    logic [DW-1:0] xr;
    logic [DW-1:0] yr;
    logic [DW-1:0] zr;
    logic [DW-1:0] zi;
    logic [DW-1:0] zi2;
    logic          wt_first;

    assign dbg_state = state;

    // Conversion FSM. Commands and operands are set on the edge into ISSn so
    // the registered command is visible for exactly the ISSn cycle. zi3 goes
    // straight into eng_b for op5 because nothing else reads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            inf      <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            eng_mode <= M_IDLE;
            eng_a    <= '0;
            eng_b    <= '0;
            xr       <= '0;
            yr       <= '0;
            zr       <= '0;
            zi       <= '0;
            zi2      <= '0;
            wt_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= X;
                        yr    <= Y;
                        zr    <= Z;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (zr == '0) begin
                        inf   <= 1'b1;
                        x_out <= '0;
                        y_out <= '0;
                        state <= FIN;
                    end else begin
                        inf      <= 1'b0;
                        eng_mode <= M_INV;
                        eng_a    <= zr;
                        eng_b    <= '0;
                        state    <= ISS1;
                    end
                end
                ISS1, ISS2, ISS3, ISS4, ISS5: begin
                    eng_mode <= M_IDLE;
                    wt_first <= 1'b1;
                    case (state)
                        ISS1:    state <= WT1;
                        ISS2:    state <= WT2;
                        ISS3:    state <= WT3;
                        ISS4:    state <= WT4;
                        default: state <= WT5;
                    endcase
                end
                WT1: begin
                    if (wt_first) begin
                        wt_first <= 1'b0;
                    end else if (eng_finish) begin
                        zi       <= eng_res;
                        eng_mode <= M_SQU;
                        eng_a    <= eng_res;
                        eng_b    <= '0;
                        state    <= ISS2;
                    end
                end
                WT2: begin
                    if (wt_first) begin
                        wt_first <= 1'b0;
                    end else if (eng_finish) begin
                        zi2      <= eng_res;
                        eng_mode <= M_MUL;
                        eng_a    <= xr;
                        eng_b    <= eng_res;
                        state    <= ISS3;
                    end
                end
                WT3: begin
                    if (wt_first) begin
                        wt_first <= 1'b0;
                    end else if (eng_finish) begin
                        x_out    <= eng_res;
                        eng_mode <= M_MUL;
                        eng_a    <= zi2;
                        eng_b    <= zi;
                        state    <= ISS4;
                    end
                end
                WT4: begin
                    if (wt_first) begin
                        wt_first <= 1'b0;
                    end else if (eng_finish) begin
                        eng_mode <= M_MUL;
                        eng_a    <= yr;
                        eng_b    <= eng_res;
                        state    <= ISS5;
                    end
                end
                WT5: begin
                    if (wt_first) begin
                        wt_first <= 1'b0;
                    end else if (eng_finish) begin
                        y_out <= eng_res;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
